// File: rtl/axi4_cmd_pkg.sv
// Shared types and helpers for the AXI4 command-stream initiator.
// FSM states, fixed AXI attribute values and response/boundary arithmetic.
package axi4_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE, AW, W, B, AR, R, DONE, ERR
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] AXCACHE     = 4'b0011;

    // Responses are ordered OKAY < EXOKAY < SLVERR < DECERR, so the
    // numeric encoding already gives the severity ordering.
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    // True when a burst starting at page offset off runs past the 4KB page.
    function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len,
                                        input logic [31:0] bytes);
        logic [31:0] end_b;
        end_b = {20'd0, off} + ({24'd0, len} + 32'd1) * bytes;
        return end_b > 32'd4096;
    endfunction

endpackage

// File: rtl/axi4_cmd_master.sv
// AXI4 initiator: one stream command becomes one INCR burst, single outstanding.
// Write beats pass through from wr_*, read beats pass through to rd_*, done_* reports.
module axi4_cmd_master
    import axi4_cmd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    // command stream
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [ID_W-1:0]     cmd_id_i,
    input  logic [ADDR_W-1:0]   cmd_addr_i,
    input  logic [7:0]          cmd_len_i,
    // write data stream
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_strb_i,
    // read data stream
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [DATA_W-1:0]   rd_data_o,
    output logic                rd_last_o,
    output logic [1:0]          rd_resp_o,
    // completion
    output logic                done_valid_o,
    output logic [ID_W-1:0]     done_id_o,
    output logic [1:0]          done_resp_o,
    // AXI4 AW
    output logic [ID_W-1:0]     awid_o,
    output logic [ADDR_W-1:0]   awaddr_o,
    output logic [7:0]          awlen_o,
    output logic [2:0]          awsize_o,
    output logic [1:0]          awburst_o,
    output logic                awlock_o,
    output logic [3:0]          awcache_o,
    output logic [2:0]          awprot_o,
    output logic [3:0]          awqos_o,
    output logic [3:0]          awregion_o,
    output logic                awvalid_o,
    input  logic                awready_i,
    // AXI4 W
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    output logic                wlast_o,
    output logic                wvalid_o,
    input  logic                wready_i,
    // AXI4 B
    input  logic [ID_W-1:0]     bid_i,
    input  logic [1:0]          bresp_i,
    input  logic                bvalid_i,
    output logic                bready_o,
    // AXI4 AR
    output logic [ID_W-1:0]     arid_o,
    output logic [ADDR_W-1:0]   araddr_o,
    output logic [7:0]          arlen_o,
    output logic [2:0]          arsize_o,
    output logic [1:0]          arburst_o,
    output logic                arlock_o,
    output logic [3:0]          arcache_o,
    output logic [2:0]          arprot_o,
    output logic [3:0]          arqos_o,
    output logic [3:0]          arregion_o,
    output logic                arvalid_o,
    input  logic                arready_i,
    // AXI4 R
    input  logic [ID_W-1:0]     rid_i,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic [1:0]          rresp_i,
    input  logic                rlast_i,
    input  logic                rvalid_i,
    output logic                rready_o
);

    localparam int          STRB_W = DATA_W / 8;
    localparam logic [2:0]  AXSIZE = 3'($clog2(STRB_W));
    localparam logic [31:0] BYTES  = 32'(STRB_W);

    state_e            state_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [8:0]        cnt_q;
    logic [1:0]        err_q;
    logic              awvalid_q;
    logic              arvalid_q;
    logic              done_valid_q;
    logic [1:0]        done_resp_q;

    logic              cmd_fire;
    logic              w_fire;
    logic              b_fire;
    logic              r_fire;
    logic              beat_last;
    logic              in_w;
    logic              in_r;
    logic [1:0]        r_err_d;
    logic [1:0]        b_resp_d;

    assign in_w      = (state_q == W);
    assign in_r      = (state_q == R);
    assign beat_last = (cnt_q == {1'b0, len_q});

    assign cmd_ready_o = (state_q == IDLE);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;

    // Address channels come straight from the latched command.
    assign awid_o     = id_q;
    assign awaddr_o   = addr_q;
    assign awlen_o    = len_q;
    assign awsize_o   = AXSIZE;
    assign awburst_o  = BURST_INCR;
    assign awlock_o   = 1'b0;
    assign awcache_o  = AXCACHE;
    assign awprot_o   = 3'b000;
    assign awqos_o    = 4'd0;
    assign awregion_o = 4'd0;
    assign awvalid_o  = awvalid_q;

    assign arid_o     = id_q;
    assign araddr_o   = addr_q;
    assign arlen_o    = len_q;
    assign arsize_o   = AXSIZE;
    assign arburst_o  = BURST_INCR;
    assign arlock_o   = 1'b0;
    assign arcache_o  = AXCACHE;
    assign arprot_o   = 3'b000;
    assign arqos_o    = 4'd0;
    assign arregion_o = 4'd0;
    assign arvalid_o  = arvalid_q;

    // W passes through while in W; the valid never depends on wready.
    assign wvalid_o   = in_w & wr_valid_i;
    assign wr_ready_o = in_w & wready_i;
    assign wdata_o    = in_w ? wr_data_i : '0;
    assign wstrb_o    = in_w ? wr_strb_i : '0;
    assign wlast_o    = in_w & beat_last;
    assign w_fire     = wvalid_o & wready_i;

    assign bready_o = (state_q == B);
    assign b_fire   = bvalid_i & bready_o;

    assign rready_o   = in_r & rd_ready_i;
    assign rd_valid_o = in_r & rvalid_i;
    assign rd_data_o  = in_r ? rdata_i : '0;
    assign rd_last_o  = in_r & rlast_i;
    assign rd_resp_o  = in_r ? rresp_i : 2'b00;
    assign r_fire     = rvalid_i & rready_o;

    assign done_valid_o = done_valid_q;
    assign done_id_o    = id_q;
    assign done_resp_o  = done_resp_q;

    // Wrong ID, beats past len+1, or an early/late rlast all count as SLVERR.
    always_comb begin
        r_err_d = resp_max(err_q, rresp_i);
        if ((rid_i != id_q) || (cnt_q > {1'b0, len_q}) || (rlast_i && !beat_last))
            r_err_d = resp_max(r_err_d, RESP_SLVERR);
    end

    assign b_resp_d = (bid_i != id_q) ? RESP_SLVERR : resp_max(bresp_i, err_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            err_q        <= RESP_OKAY;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: if (cmd_fire) begin
                    id_q   <= cmd_id_i;
                    addr_q <= cmd_addr_i;
                    len_q  <= cmd_len_i;
                    cnt_q  <= '0;
                    err_q  <= RESP_OKAY;
                    if (crosses_4k(cmd_addr_i[11:0], cmd_len_i, BYTES)) begin
                        state_q      <= ERR;
                        done_valid_q <= 1'b1;
                        done_resp_q  <= RESP_SLVERR;
                    end else if (cmd_write_i) begin
                        state_q   <= AW;
                        awvalid_q <= 1'b1;
                    end else begin
                        state_q   <= AR;
                        arvalid_q <= 1'b1;
                    end
                end
                AW: if (awready_i) begin
                    awvalid_q <= 1'b0;
                    state_q   <= W;
                end
                W: if (w_fire) begin
                    cnt_q <= cnt_q + 9'd1;
                    if (beat_last) state_q <= B;
                end
                B: if (b_fire) begin
                    done_valid_q <= 1'b1;
                    done_resp_q  <= b_resp_d;
                    state_q      <= DONE;
                end
                AR: if (arready_i) begin
                    arvalid_q <= 1'b0;
                    state_q   <= R;
                end
                R: if (r_fire) begin
                    // Saturate so a runaway slave cannot wrap back to a "correct" count.
                    if (cnt_q != 9'h1FF) cnt_q <= cnt_q + 9'd1;
                    err_q <= r_err_d;
                    if (rlast_i) begin
                        done_valid_q <= 1'b1;
                        done_resp_q  <= r_err_d;
                        state_q      <= DONE;
                    end
                end
                DONE, ERR: begin
                    done_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_cmd_master.sv
// Directed bench for axi4_cmd_master: the initial block plays both the command
// source and the AXI slave, driving and sampling on the falling clock edge.
module tb_axi4_cmd_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 0, cmd_write = 0, cmd_ready;
    logic [3:0]  cmd_id = 0;
    logic [31:0] cmd_addr = 0;
    logic [7:0]  cmd_len = 0;
    logic        wr_valid = 0, wr_ready;
    logic [31:0] wr_data = 0;
    logic [3:0]  wr_strb = 0;
    logic        rd_valid, rd_ready = 0, rd_last;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        done_valid;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  awid, awcache, awqos, awregion, arid, arcache, arqos, arregion;
    logic [31:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, awprot, arsize, arprot;
    logic [1:0]  awburst, arburst;
    logic        awlock, awvalid, awready = 0, arlock, arvalid, arready = 0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready = 0;
    logic [3:0]  bid = 0, rid = 0;
    logic [1:0]  bresp = 0, rresp = 0;
    logic        bvalid = 0, bready;
    logic [31:0] rdata = 0;
    logic        rlast = 0, rvalid = 0, rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi4_cmd_master #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_id_i(cmd_id), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_last_o(rd_last), .rd_resp_o(rd_resp),
        .done_valid_o(done_valid), .done_id_o(done_id), .done_resp_o(done_resp),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
        .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
        .awqos_o(awqos), .awregion_o(awregion), .awvalid_o(awvalid), .awready_i(awready),
        .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
        .arqos_o(arqos), .arregion_o(arregion), .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
        .rvalid_i(rvalid), .rready_o(rready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Full write burst; one stall cycle on beat 1 exercises the W hold.
    task automatic run_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [3:0] b_id, input logic [1:0] b_resp, input logic [1:0] exp);
        cmd_valid = 1; cmd_write = 1; cmd_id = id; cmd_addr = addr; cmd_len = len;
        #1 chk("wr_cmd_ready", cmd_ready, 1);
        @(negedge clk); cmd_valid = 0;
        #1 chk("awvalid", awvalid, 1);
        chk("awaddr", awaddr, addr);
        chk("awlen", awlen, len);
        chk("awid", awid, id);
        awready = 1;
        @(negedge clk); awready = 0;
        #1 chk("awvalid_drop", awvalid, 0);
        for (int b = 0; b <= len; b++) begin
            wr_valid = 1; wr_data = 32'hA0 + b; wr_strb = 4'hF;
            if (b == 1) begin
                wready = 0;
                #1 chk("w_stall_wr_ready", wr_ready, 0);
                chk("w_stall_wvalid", wvalid, 1);
                @(negedge clk);
            end
            wready = 1;
            #1 chk("wvalid", wvalid, 1);
            chk("wdata", wdata, 32'hA0 + b);
            chk("wstrb", wstrb, 4'hF);
            chk("wlast", wlast, b == len);
            @(negedge clk);
        end
        wr_valid = 0; wready = 0;
        #1 chk("w_done_wvalid", wvalid, 0);
        chk("bready", bready, 1);
        bvalid = 1; bid = b_id; bresp = b_resp;
        @(negedge clk); bvalid = 0;
        #1 chk("wr_done_valid", done_valid, 1);
        chk("wr_done_id", done_id, id);
        chk("wr_done_resp", done_resp, exp);
        chk("wr_done_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        #1 chk("wr_done_clear", done_valid, 0);
        chk("wr_idle_cmd_ready", cmd_ready, 1);
    endtask

    task automatic issue_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        cmd_valid = 1; cmd_write = 0; cmd_id = id; cmd_addr = addr; cmd_len = len;
        @(negedge clk); cmd_valid = 0;
        #1 chk("arvalid", arvalid, 1);
        chk("araddr", araddr, addr);
        chk("arlen", arlen, len);
        chk("rd_no_awvalid", awvalid, 0);
        arready = 1;
        @(negedge clk); arready = 0;
        #1 chk("arvalid_drop", arvalid, 0);
    endtask

    task automatic expect_done(input string tag, input logic [3:0] id, input logic [1:0] exp);
        #1 chk({tag, "_done_valid"}, done_valid, 1);
        chk({tag, "_done_id"}, done_id, id);
        chk({tag, "_done_resp"}, done_resp, exp);
        @(negedge clk);
        #1 chk({tag, "_done_clear"}, done_valid, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int beat;
        // reset state
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("awsize", awsize, 2);
        chk("awburst", awburst, 1);
        chk("arsize", arsize, 2);
        chk("awcache", awcache, 4'b0011);
        chk("arcache", arcache, 4'b0011);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        run_write(4'd5, 32'h100, 8'd3, 4'd5, 2'b00, 2'b00);

        // single-beat read
        issue_read(4'd2, 32'h2000, 8'd0);
        rvalid = 1; rid = 2; rdata = 32'hDEADBEEF; rlast = 1; rresp = 0; rd_ready = 1;
        #1 chk("r0_rready", rready, 1);
        chk("r0_rd_valid", rd_valid, 1);
        chk("r0_rd_data", rd_data, 32'hDEADBEEF);
        chk("r0_rd_last", rd_last, 1);
        chk("r0_rd_resp", rd_resp, 0);
        @(negedge clk); rvalid = 0; rlast = 0;
        expect_done("r0", 4'd2, 2'b00);

        // 8-beat read, rd_ready toggling, SLVERR on beat 4
        issue_read(4'd3, 32'h3000, 8'd7);
        beat = 0;
        for (int c = 0; c < 40 && beat < 8; c++) begin
            rd_ready = c[0];
            rvalid = 1; rid = 3; rdata = 32'h100 + beat;
            rlast = (beat == 7); rresp = (beat == 4) ? 2'b10 : 2'b00;
            #1 chk("r7_rready", rready, c[0]);
            chk("r7_rd_valid", rd_valid, 1);
            if (rd_ready) begin
                chk("r7_rd_data", rd_data, 32'h100 + beat);
                chk("r7_rd_last", rd_last, beat == 7);
                beat++;
            end
            @(negedge clk);
        end
        rvalid = 0; rlast = 0; rresp = 0; rd_ready = 0;
        chk("r7_beats", beat, 8);
        expect_done("r7", 4'd3, 2'b10);

        // write crossing 4KB: 0xFF8 + 16 bytes
        cmd_valid = 1; cmd_write = 1; cmd_id = 6; cmd_addr = 32'hFF8; cmd_len = 3;
        @(negedge clk); cmd_valid = 0;
        #1 chk("x4k_awvalid", awvalid, 0);
        chk("x4k_arvalid", arvalid, 0);
        expect_done("x4k_wr", 4'd6, 2'b10);
        #1 chk("x4k_awvalid_after", awvalid, 0);

        // read crossing 4KB: 0xFFC + 8 bytes
        cmd_valid = 1; cmd_write = 0; cmd_id = 9; cmd_addr = 32'hFFC; cmd_len = 1;
        @(negedge clk); cmd_valid = 0;
        #1 chk("x4k_rd_arvalid", arvalid, 0);
        expect_done("x4k_rd", 4'd9, 2'b10);

        // ends exactly on the page boundary: legal
        run_write(4'd1, 32'hFF0, 8'd3, 4'd1, 2'b00, 2'b00);
        // BID mismatch forces SLVERR
        run_write(4'd1, 32'h40, 8'd1, 4'd2, 2'b00, 2'b10);
        // EXOKAY propagates
        run_write(4'd7, 32'h80, 8'd0, 4'd7, 2'b01, 2'b01);

        // early rlast on beat 1 of a 4-beat read
        issue_read(4'd4, 32'h400, 8'd3);
        rvalid = 1; rid = 4; rdata = 32'h11; rlast = 0; rd_ready = 1;
        @(negedge clk);
        rdata = 32'h22; rlast = 1;
        #1 chk("early_rd_data", rd_data, 32'h22);
        @(negedge clk); rvalid = 0; rlast = 0;
        #1 chk("early_rready_done", rready, 0);
        expect_done("early", 4'd4, 2'b10);
        rd_ready = 0;

        // reset during beat 2 of an 8-beat write
        cmd_valid = 1; cmd_write = 1; cmd_id = 7; cmd_addr = 32'h500; cmd_len = 7;
        @(negedge clk); cmd_valid = 0; awready = 1;
        @(negedge clk); awready = 0;
        wr_valid = 1; wready = 1;
        @(negedge clk); @(negedge clk);
        wready = 0;
        #1 chk("mid_wvalid_pre", wvalid, 1);
        rst_n = 0;
        #1 chk("mid_wvalid", wvalid, 0);
        chk("mid_awvalid", awvalid, 0);
        chk("mid_bready", bready, 0);
        chk("mid_done_valid", done_valid, 0);
        wr_valid = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("post_rst_done", done_valid, 0);
            chk("post_rst_cmd_ready", cmd_ready, 1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi4_cmd_master.md
Name: axi4_cmd_master

Overview:
- Synthesizable AXI4 initiator that turns simple stream commands into AXI4 INCR bursts on a full AXI4 master port.
- Used to exercise AXI4 slave/interconnect RTL, and as the stimulus engine facing slave-side agents.
- Single outstanding transaction: one read or one write at a time.
- Write data arrives on a valid/ready stream; read data leaves on a valid/ready stream; a completion pulse reports id and response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; power of 2, 32..1024
ID_W, 4, AXI ID width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_id  in  ID_W  transaction ID
cmd_addr  in  ADDR_W  start address, size-aligned
cmd_len  in  8  beats minus 1 (AXI len)
wr_valid/wr_ready  in/out  1  write-data stream handshake
wr_data  in  DATA_W  write beat data
wr_strb  in  DATA_W/8  write beat strobes
rd_valid/rd_ready  out/in  1  read-data stream handshake
rd_data  out  DATA_W  read beat data
rd_last  out  1  last read beat
rd_resp  out  2  RRESP of beat
done_valid  out  1  one-cycle completion pulse
done_id  out  ID_W  ID of completed transaction
done_resp  out  2  worst response of transaction
aw*/w*/b*/ar*/r*  AXI4 master  std  full AXI4 channels
awlock/awcache/awprot/awqos/awregion, ar equivalents  out  std  constants 0,4'b0011,3'b000,0,0

Behaviour:
- Reset (rst_n low, async): state IDLE; cmd_ready=1; awvalid, wvalid, bready, arvalid, rready, rd_valid, done_valid = 0; all data/addr outputs = 0.
- Constants: awsize/arsize = log2(DATA_W/8); awburst/arburst = 2'b01 INCR.
- Command acceptance:
  - cmd_ready=1 only in IDLE; accept on cmd_valid&cmd_ready.
  - Latch id/addr/len; clear beat counter and error accumulator.
- 4KB check: if addr[11:0] + (len+1)*DATA_W/8 > 4096:
  - go to ERR; no AXI traffic issued.
  - Next cycle: done_valid=1, done_resp=2'b10; return to IDLE.
- Write path:
  - AW: awvalid=1 with latched fields from the cycle after acceptance until awready.
  - W: wvalid=wr_valid, wr_ready=wready, wdata/wstrb pass through; wlast=1 when beat count==len; count increments on wvalid&wready; leave after the last beat.
  - B: bready=1; on bvalid, done_valid=1 the following cycle with done_resp=max(bresp, err_acc), done_id; then IDLE.
  - bid!=id -> done_resp forced 2'b10.
- Read path:
  - AR: arvalid=1 until arready.
  - R: rready=rd_ready; rd_valid=rvalid; rd_data/rd_last/rd_resp pass through; count increments on rvalid&rready.
  - err_acc = max(err_acc, rresp); rid!=id -> err_acc=2'b10.
  - On accepted rlast: error 2'b10 if count!=len. Beats beyond len+1 without rlast are accepted and flagged 2'b10. Then done as above; IDLE.
- AXI rules:
  - No valid is deasserted before its handshake.
  - Address/data are stable while valid.
  - No combinational path from any ready to its own valid.
- Latency: awvalid/arvalid assert 1 cycle after command acceptance; done_valid asserts 1 cycle after the B or last-R handshake.
- Next command can be accepted the cycle after done_valid.
- Simultaneous events: cmd_valid during done_valid is not accepted (cmd_ready=0).
- Reset mid-burst: all valids drop immediately; partial transaction is abandoned with no done pulse.
- resp ordering for max(): OKAY 00 < EXOKAY 01 < SLVERR 10 < DECERR 11.

Decomposition:
- Shared package axi4_cmd_pkg: state enum (IDLE, AW, W, B, AR, R, DONE, ERR), AXI burst/resp constants, resp_max function, 4KB-cross function.
- No sub-module; one always_ff FSM plus combinational channel muxing.

Test Plan:
- Write len=3, addr=0x100, id=5, 4 beats 0xA0..0xA3, strb=0xF, bresp=00:
  - awaddr=0x100, awlen=3; wlast on beat 3 only.
  - done_id=5, done_resp=00.
- Read len=0, addr=0x2000, slave returns rdata=0xDEADBEEF, rlast=1, rresp=00: rd_data=0xDEADBEEF, rd_last=1, done_resp=00.
- Read len=7 with rd_ready toggling every cycle and rresp=10 on beat 4: rready tracks rd_ready; all 8 beats delivered in order; done_resp=10.
- Command addr=0xFF8, len=3, DATA_W=32 (crosses 4KB): no awvalid/arvalid ever; done_valid next cycle with resp=10.
- Read len=3, slave asserts rlast on beat 1: transaction ends after 2 beats; done_resp=10.
- Assert rst_n=0 during W beat 2 of len=7 write: wvalid/awvalid/bready=0 immediately; no done_valid; cmd_ready=1 after reset release.
